// File: rtl/aes_pkg.sv
// Shared AES-128 constants, GF(2^8) helpers and the key-schedule FSM state type.
package aes_pkg;

  localparam int unsigned AES_NR     = 10;
  localparam logic [3:0]  LAST_ROUND = 4'(AES_NR);
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  XTIME_POLY = 8'h1b;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box: combinational 256-entry byte substitution table.
module sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  localparam logic [7:0] SBOX_LUT [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_data = SBOX_LUT[i_data];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts one cipher key and streams round keys
// 0..10 over a valid/ready port, computing each next key combinationally from the current one.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_w;
  logic [3:0]   r_index;
  logic [7:0]   r_rcon;
  logic         r_done;

  logic         w_accept;
  logic         w_hs;
  logic         w_last;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;

  assign w_accept = key_valid && (r_state == IDLE);
  assign w_hs     = (r_state == STREAM) && rk_ready;
  assign w_last   = (r_index == LAST_ROUND);

  // Next round key: one S-box stage followed by the word XOR chain.
  assign {w_w0, w_w1, w_w2, w_w3} = r_w;
  assign w_rot = rot_word(w_w3);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    sbox u_sbox (
      .i_data (w_rot[8*g +: 8]),
      .o_data (w_sub[8*g +: 8])
    );
  end

  assign w_temp = w_sub ^ {r_rcon, 24'h0};
  assign w_n0   = w_w0 ^ w_temp;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (key_valid)         w_state_nxt = STREAM;
      STREAM:  if (rk_ready && w_last) w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    key_ready = (r_state == IDLE);
    rk_valid  = (r_state == STREAM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w     <= '0;
      r_index <= '0;
      r_rcon  <= RCON_INIT;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      if (w_accept) begin
        r_w     <= key_in;
        r_index <= 4'd0;
        r_rcon  <= RCON_INIT;
      end else if (w_hs && !w_last) begin
        r_w     <= {w_n0, w_n1, w_n2, w_n3};
        r_index <= r_index + 4'd1;
        r_rcon  <= xtime(r_rcon);
      end
    end
  end

  assign rk_data  = r_w;
  assign rk_index = r_index;
  assign done     = r_done;

endmodule
